// File: rtl/sub8_serial_if.sv
// rtl/sub8_serial_if.sv - request/result bundle between a controller and the serial subtractor
interface sub8_serial_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         busy;
    logic         done;
    logic [W-1:0] x;
    logic         r;

    modport master (output start, a, b, c, input busy, done, x, r);
    modport slave  (input start, a, b, c, output busy, done, x, r);
endinterface

// File: rtl/sub8_serial.sv
// rtl/sub8_serial.sv - bit-serial W-bit subtractor X = A - B - C, LSB first, with borrow-out R
module sub8_serial #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    sub8_serial_if.slave   bus
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  x_q, x_d;
    logic          bw_q, bw_d;
    logic          r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          diff_bit;
    logic          bw_next;

    // One full-subtractor cell operating on the current LSBs of the shifting operands.
    assign diff_bit = sa_q[0] ^ sb_q[0] ^ bw_q;
    assign bw_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        x_d     = x_q;
        bw_d    = bw_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    bw_d    = bus.c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bw_d  = bw_next;
                acc_d = {diff_bit, acc_q[W-1:1]};
                sa_d  = {1'b0, sa_q[W-1:1]};
                sb_d  = {1'b0, sb_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    x_d     = {diff_bit, acc_q[W-1:1]};
                    r_d     = bw_next;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            bw_q    <= 1'b0;
            r_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            bw_q    <= bw_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_FIN);
    assign bus.x    = x_q;
    assign bus.r    = r_q;
endmodule

// File: tb/tb_sub8_serial.sv
// tb/tb_sub8_serial.sv - randomized self-checking bench for sub8_serial against an arithmetic model
module tb_sub8_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic [W-1:0] last_x = '0;
    logic         last_r = 1'b0;

    sub8_serial_if #(.W(W)) bus ();

    sub8_serial #(.W(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain signed arithmetic: borrow-out is simply whether the true difference went negative.
    function automatic logic [W:0] ref_sub(input int a, input int b, input int c);
        int d;
        d = a - b - c;
        return {(d < 0) ? 1'b1 : 1'b0, d[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        tick();
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.c = c;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.c = $urandom;
    endtask

    task automatic wait_done(input string tag, input int a, input int b, input int c, input int elapsed);
        logic [W:0] exp;
        int   n;
        int   s;
        logic hold_ok;
        logic busy_ok;
        exp     = ref_sub(a, b, c);
        n       = elapsed;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        while (!bus.done && n < W + 4) begin
            if (bus.x !== last_x || bus.r !== last_r) hold_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, W);
        check({tag, "_hold"}, hold_ok, 1);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_x"}, bus.x, exp[W-1:0]);
        check({tag, "_r"}, bus.r, exp[W]);
        s = int'(bus.x) + b + c;
        check({tag, "_add_a"}, s % (1 << W), a);
        check({tag, "_add_co"}, s >> W, bus.r);
        last_x = exp[W-1:0];
        last_r = exp[W];
        tick();
        check({tag, "_pulse"}, bus.done, 0);
    endtask

    initial begin
        int corners [3];
        int ta [3];
        int tb_ [3];
        int tc [3];
        int done_cyc [3];
        int n;
        int seen;
        logic [W-1:0] ra, rb;
        logic rc;

        corners = '{0, 'h80, 'hFF};
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_x", bus.x, 0);
        check("rst_r", bus.r, 0);
        repeat (3) tick();
        rst_n = 1'b1;

        start_op(8'h50, 8'h30, 1'b0);
        wait_done("t1", 'h50, 'h30, 0, 0);

        start_op(8'h00, 8'h01, 1'b0);
        wait_done("t2a", 'h00, 'h01, 0, 0);
        start_op(8'h10, 8'h10, 1'b1);
        wait_done("t2b", 'h10, 'h10, 1, 0);
        start_op(8'hFF, 8'hFF, 1'b0);
        wait_done("t2c", 'hFF, 'hFF, 0, 0);

        start_op(8'h50, 8'h30, 1'b0);
        wait_done("t3pre", 'h50, 'h30, 0, 0);
        start_op(8'h05, 8'h07, 1'b0);
        tick();
        bus.start = 1'b1;
        bus.a = 8'h99;
        bus.b = 8'h11;
        bus.c = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_done("t3", 'h05, 'h07, 0, 2);
        check("t3_fe", last_x, 'hFE);
        repeat (3) tick();
        check("t3_no_second", bus.busy, 0);

        start_op(8'h3C, 8'h21, 1'b1);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", bus.busy, 0);
        check("t4_done", bus.done, 0);
        check("t4_x", bus.x, 0);
        check("t4_r", bus.r, 0);
        last_x = '0;
        last_r = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) seen = 1;
        end
        check("t4_no_done", seen, 0);
        start_op(8'h3C, 8'h21, 1'b1);
        wait_done("t4_after", 'h3C, 'h21, 1, 0);

        for (int i = 0; i < 3; i++) begin
            ta[i]  = $urandom_range(0, 255);
            tb_[i] = $urandom_range(0, 255);
            tc[i]  = $urandom_range(0, 1);
        end
        tick();
        bus.start = 1'b1;
        bus.a = ta[0];
        bus.b = tb_[0];
        bus.c = tc[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            logic [W:0] e;
            n = 0;
            while (!bus.done && n < W + 6) begin
                tick();
                n++;
            end
            done_cyc[i] = cyc;
            e = ref_sub(ta[i], tb_[i], tc[i]);
            check("t5_x", bus.x, e[W-1:0]);
            check("t5_r", bus.r, e[W]);
            last_x = e[W-1:0];
            last_r = e[W];
            if (i < 2) begin
                bus.a = ta[i+1];
                bus.b = tb_[i+1];
                bus.c = tc[i+1];
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        check("t5_gap01", done_cyc[1] - done_cyc[0], W + 2);
        check("t5_gap12", done_cyc[2] - done_cyc[1], W + 2);

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 2; k++) begin
                    start_op(corners[i], corners[j], k[0]);
                    wait_done("corner", corners[i], corners[j], k, 0);
                end

        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            start_op(ra, rb, rc);
            wait_done("rand", int'(ra), int'(rb), int'(rc), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
